seg7_scan: RTL and testbench

- Multiplexed common-anode hex seven-segment driver.
- Sits directly downstream of divide_clk and consumes its divided_clk output as the digit-scan rate.
- Everything runs in the single clk domain. divided_clk is sampled and edge-detected into a one-cycle scan tick; it is never used as a clock.
- Holds a latched hex value and walks one digit per tick, driving active-low anode and segment lines.

---
 rtl/seg7_scan_if.sv | 23 ++
 rtl/seg7_scan.sv | 98 +++++++++
 tb/tb_seg7_scan.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Scan driver bundle: scan-rate input, load port and
// active-low display lines for seg7_scan.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  divided_clk;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp_out;

  modport master (
    output divided_clk, load, value, dp,
    input  an, seg, dp_out
  );

  modport slave (
    input  divided_clk, load, value, dp,
    output an, seg, dp_out
  );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed common-anode hex 7-segment driver.
// divided_clk is edge-detected into a scan tick in the clk domain.
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 0
) (
  input logic         clk,
  input logic         rst,
  seg7_scan_if.slave  bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic                div_q;
  logic                tick;
  logic [IW-1:0]       idx;
  logic [VW-1:0]       value_r;
  logic [DIGITS-1:0]   dp_r;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   lz;
  logic                blank;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_d;
  logic                dp_d;

  function automatic logic [6:0] hex_font(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = bus.divided_clk & ~div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= 1'b0;
      idx     <= '0;
      value_r <= '0;
      dp_r    <= '0;
    end else begin
      div_q <= bus.divided_clk;
      if (tick)
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
      if (bus.load) begin
        value_r <= bus.value;
        dp_r    <= bus.dp;
      end
    end
  end

  // lz[i]: digit i and every digit above it are zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (value_r[VW-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] & (value_r[4*i +: 4] == 4'h0);
  end

  always_comb begin
    nib   = value_r[{idx, 2'b00} +: 4];
    blank = (BLANK_LZ != 0) && (idx != '0) && lz[idx];
    an_d  = ~(DIGITS'(1) << idx);
    seg_d = blank ? 7'h7F : hex_font(nib);
    dp_d  = ~dp_r[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.an     <= '1;
      bus.seg    <= 7'h7F;
      bus.dp_out <= 1'b1;
    end else begin
      bus.an     <= an_d;
      bus.seg    <= seg_d;
      bus.dp_out <= dp_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// Randomized plus directed bench for seg7_scan, plain and
// leading-zero-blanking builds checked against a digit-level model.
module tb_seg7_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_in = 1'b0;
  logic        ld_in = 1'b0;
  logic [15:0] val_in = '0;
  logic [3:0]  dp_in = '0;

  int checks = 0;
  int failures = 0;

  seg7_scan_if #(.DIGITS(4)) bus0 ();
  seg7_scan_if #(.DIGITS(4)) bus1 ();

  assign bus0.divided_clk = div_in;
  assign bus0.load        = ld_in;
  assign bus0.value       = val_in;
  assign bus0.dp          = dp_in;
  assign bus1.divided_clk = div_in;
  assign bus1.load        = ld_in;
  assign bus1.value       = val_in;
  assign bus1.dp          = dp_in;

  seg7_scan #(.DIGITS(4), .BLANK_LZ(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seg7_scan #(.DIGITS(4), .BLANK_LZ(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          m_idx = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  bit          m_prev = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg0;
  logic [6:0]  e_seg1;
  logic        e_dpo;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one clock: model the edge, then compare both builds
  task automatic step();
    int d;
    @(posedge clk);
    if (rst) begin
      e_an   = 4'hF;
      e_seg0 = 7'h7F;
      e_seg1 = 7'h7F;
      e_dpo  = 1'b1;
      m_idx  = 0;
      m_prev = 1'b0;
      m_val  = '0;
      m_dp   = '0;
    end else begin
      e_an   = 4'hF & ~(4'h1 << m_idx);
      d      = int'((m_val >> (4 * m_idx)) & 16'hF);
      e_seg0 = font[d];
      e_seg1 = (m_idx > 0 && (m_val >> (4 * m_idx)) == 0)
               ? 7'h7F : font[d];
      e_dpo  = ~m_dp[m_idx];
      if (div_in && !m_prev) m_idx = (m_idx + 1) % 4;
      if (ld_in) begin
        m_val = val_in;
        m_dp  = dp_in;
      end
      m_prev = div_in;
    end
    @(negedge clk);
    check("an0",  32'(bus0.an),     32'(e_an));
    check("seg0", 32'(bus0.seg),    32'(e_seg0));
    check("dpo0", 32'(bus0.dp_out), 32'(e_dpo));
    check("an1",  32'(bus1.an),     32'(e_an));
    check("seg1", 32'(bus1.seg),    32'(e_seg1));
    check("dpo1", 32'(bus1.dp_out), 32'(e_dpo));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    ld_in  = 1'b1;
    val_in = v;
    dp_in  = p;
    step();
    ld_in  = 1'b0;
  endtask

  task automatic seek_idx(input int target);
    for (int n = 0; n < 40 && m_idx != target; n++) begin
      div_in = ~div_in;
      step();
    end
    check("seek_idx", 32'(m_idx), 32'(target));
  endtask

  initial begin
    int i0;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      div_in = ~div_in;
      step();
    end
    rst = 1'b0;
    div_in = 1'b0;
    do_load(16'h12A8, 4'h0);
    check("idx_after_rst", 32'(m_idx), 32'd0);
    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 1) div_in = ~div_in;
      step();
    end

    div_in = 1'b0;
    step();
    i0 = m_idx;
    div_in = 1'b1;
    for (int n = 0; n < 10; n++) step();
    step();
    check("hold_hi_an", 32'(bus0.an),
          32'(4'hF & ~(4'h1 << ((i0 + 1) % 4))));

    div_in = 1'b0;
    seek_idx(2);
    div_in = 1'b0;
    step();
    div_in = 1'b1;
    do_load(16'hF000, 4'h0);
    step();
    check("coll_an",  32'(bus0.an),  32'h7);
    check("coll_seg", 32'(bus0.seg), 32'h0E);

    div_in = 1'b0;
    do_load(16'h0010, 4'b1000);
    for (int n = 0; n < 24; n++) begin
      div_in = ~div_in;
      step();
    end

    seek_idx(2);
    rst = 1'b1;
    step();
    check("mid_rst_an", 32'(bus0.an), 32'hF);
    rst = 1'b0;
    div_in = 1'b0;
    step();
    check("post_rst_an", 32'(bus0.an), 32'hE);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) div_in = ~div_in;
      ld_in = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0)
        val_in = 16'($urandom_range(0, 16'hFFFF));
      else
        val_in = 16'($urandom_range(0, 255));
      dp_in = 4'($urandom_range(0, 15));
      rst   = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
